ap_table_loader: RTL
====================

Name: ap_table_loader

Overview:
- Register-ring initiator (ring head) that programs and reads back entries of the AP/action table in the downstream AP lookup responder.
- Accepts one entry command at a time and expands it into the responder's staged-register sequence.
- Returns read data or completion status on a response port.
- Sits between the control-path command source and the first UDP register-ring node.

Parameters:
- AP_WIDTH, 32, width of the next-pointer/end-flag word of an entry.
- ACTION_WIDTH, 64, width of the action word of an entry.
- IDX_WIDTH, 8, table index width.
- TAG, 13'h1, register block tag of the target responder.
- REG_ADDR_WIDTH, 10, offset width inside the block.
- UDP_REG_SRC_WIDTH, 2, ring source-ID width.
- SRC_ID, 2'd0, source ID this initiator stamps on requests.
- TIMEOUT_CYCLES, 1023, maximum wait for a returning transaction.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, block idle and able to accept a command.
- cmd_wr, in, 1, 1 = write entry, 0 = read entry.
- cmd_index, in, IDX_WIDTH, table index.
- cmd_action, in, ACTION_WIDTH, action data for a write.
- cmd_ap, in, AP_WIDTH, AP data for a write.
- rsp_valid, out, 1, one-cycle response strobe.
- rsp_action, out, ACTION_WIDTH, read-back action.
- rsp_ap, out, AP_WIDTH, read-back AP.
- rsp_err, out, 2, error code: 0 ok, 1 no-ack, 2 timeout, 3 verify-mismatch.
- reg_req_out, out, 1, ring request.
- reg_ack_out, out, 1, ring ack; always 0.
- reg_rd_wr_L_out, out, 1, ring read/write-low.
- reg_addr_out, out, 23, ring address.
- reg_data_out, out, 32, ring data.
- reg_src_out, out, UDP_REG_SRC_WIDTH, ring source ID.
- reg_req_in, in, 1, returning ring request.
- reg_ack_in, in, 1, returning ring ack.
- reg_rd_wr_L_in, in, 1, returning read/write-low.
- reg_addr_in, in, 23, returning address.
- reg_data_in, in, 32, returning data.
- reg_src_in, in, UDP_REG_SRC_WIDTH, returning source ID.

Behaviour:
- Reset: all outputs 0 except cmd_ready, which is 0 during reset and 1 in the first cycle after reset. FSM goes to IDLE.
- Address map, as offsets within TAG: 0 = action[31:0], 1 = action[63:32], 2 = ap, 3 = READ_ADDR, 4 = WRITE_ADDR. The full ring address is {TAG, offset}.
- Command capture: the command is latched when cmd_valid && cmd_ready. cmd_ready drops the following cycle and stays 0 until the cycle after rsp_valid.
- Write sequence: wr(0, act_lo), wr(1, act_hi), wr(2, ap), then wr(4, {zero-extended index}).
- Read sequence: wr(3, index), then rd(0), rd(1), rd(2). Returned data is captured into rsp_action / rsp_ap.
- FSM states:
  - IDLE: on accept, load the step counter and go to ISSUE.
  - ISSUE: drive reg_req_out = 1 for exactly one cycle with addr/data/rd_wr_L/src. Write data is driven on reg_data_out; reads drive 0. Then go to WAIT.
  - WAIT: a returning transaction is accepted only if reg_req_in && reg_src_in == SRC_ID && reg_addr_in matches the issued address.
    - With reg_ack_in = 1: capture reg_data_in on reads, advance the step, then go to ISSUE, or to RESP after the last step.
    - With reg_ack_in = 0: set err = 1, go to RESP.
    - Returning transactions with another src are ignored.
    - The timeout counter starts at 0 on entry to WAIT. Reaching TIMEOUT_CYCLES sets err = 2 and goes to RESP.
  - RESP: rsp_valid = 1 for one cycle, then go to IDLE.
- Outputs between requests: reg_req_out = 0; other reg_*_out hold their last value.
- Latency: each step costs 1 + ring round-trip cycles. With a zero-delay loopback, a write completes in 4×2 + 2 cycles.
- Error abort: remaining steps are skipped. rsp_action / rsp_ap are zeroed on any error.
- Reset mid-sequence: the FSM aborts and no response is produced. Late ring returns after reset are discarded because the FSM is in IDLE.
- cmd_valid asserted during a busy period is held off by cmd_ready = 0; there is no queuing.

Optional Feature:
- AP_LOADER_VERIFY_EN defined:
  - After a successful write, the block automatically appends the full read sequence for the same index and compares against the written data.
  - A mismatch yields err = 3; rsp_action / rsp_ap carry the read-back values.
- Not defined: the write response is issued directly after the WRITE_ADDR ack.

Decomposition:
- Shared package/defines:
  - Offsets AP_ACT_LO_OFF = 0, AP_ACT_HI_OFF = 1, AP_AP_OFF = 2, AP_READ_ADDR_OFF = 3, AP_WRITE_ADDR_OFF = 4.
  - Error codes ERR_OK, ERR_NOACK, ERR_TIMEOUT, ERR_MISMATCH.
  - Ring widths 23 and 32.
- Sub-module reg_ring_xact: a single ring transaction engine covering issue, src/addr match, ack/no-ack and timeout. ap_table_loader sequences the steps through it.

Test Plan:
- Write index 5 (action 64'h00ABCDEF_00060007, ap 32'hFFFFFFFF) over a loopback responder model -> ring sees writes to {TAG,0}=32'h00060007, {TAG,1}=32'h00ABCDEF, {TAG,2}=32'hFFFFFFFF, {TAG,4}=5 in order; rsp_valid with rsp_err = 0.
- Read index 1 with the model holding {ap 32'h80000002, action 64'h0F0F0F0F_00000002} -> ring sees wr(3)=1, then rd 0/1/2; rsp_action = 64'h0F0F0F0F00000002, rsp_ap = 32'h80000002.
- Model drops the ack on step 2 (req returns, ack_in = 0) -> sequence stops with no step-3 request; rsp_err = 1; rsp_action = 0.
- Model never returns, TIMEOUT_CYCLES = 16 -> rsp_valid 17 cycles after the request; rsp_err = 2; cmd_ready re-asserts the next cycle.
- Foreign src = 2'd3 return injected during WAIT, then the correct return -> foreign return ignored; normal completion with err = 0.
- Reset asserted in the middle of a write, then a new read command -> no stale rsp_valid; the read completes correctly. With AP_LOADER_VERIFY_EN, a corrupted model readback gives rsp_err = 3.

Source files
------------

// File: rtl/ap_table_loader_pkg.sv
// Shared definitions for the AP table loader: ring widths, block offsets,
// response error codes and FSM state encoding.
package ap_table_loader_pkg;

  localparam int RING_ADDR_W = 23;
  localparam int RING_DATA_W = 32;

  localparam int AP_ACT_LO_OFF     = 0;
  localparam int AP_ACT_HI_OFF     = 1;
  localparam int AP_AP_OFF         = 2;
  localparam int AP_READ_ADDR_OFF  = 3;
  localparam int AP_WRITE_ADDR_OFF = 4;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_NOACK    = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_MISMATCH = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_ring_xact.sv
// Single register-ring transaction engine: drives one request, then watches
// the returning ring for our src/addr, reporting ack, no-ack or timeout.
module reg_ring_xact
  import ap_table_loader_pkg::*;
#(
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = '0,
  parameter int                           TIMEOUT_CYCLES    = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue,
  input  logic                         waiting,
  input  logic                         rd_wr_L,
  input  logic [RING_ADDR_W-1:0]       addr,
  input  logic [RING_DATA_W-1:0]       data,
  output logic                         done_ack,
  output logic                         done_noack,
  output logic                         done_timeout,
  output logic [RING_DATA_W-1:0]       rdata,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [RING_ADDR_W-1:0]       reg_addr_out,
  output logic [RING_DATA_W-1:0]       reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [RING_ADDR_W-1:0]       reg_addr_in,
  input  logic [RING_DATA_W-1:0]       reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic                         rd_wr_L_q;
  logic [RING_ADDR_W-1:0]       addr_q;
  logic [RING_DATA_W-1:0]       data_q;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q;
  logic [CNT_W-1:0]             tmo_cnt;
  logic                         match;

  // Ring fields hold their last issued value between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wr_L_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
    end else if (issue) begin
      rd_wr_L_q <= rd_wr_L;
      addr_q    <= addr;
      data_q    <= data;
      src_q     <= SRC_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || issue)
      tmo_cnt <= '0;
    else if (waiting)
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign reg_req_out     = issue;
  assign reg_ack_out     = 1'b0;
  assign reg_rd_wr_L_out = issue ? rd_wr_L : rd_wr_L_q;
  assign reg_addr_out    = issue ? addr    : addr_q;
  assign reg_data_out    = issue ? data    : data_q;
  assign reg_src_out     = issue ? SRC_ID  : src_q;

  assign match = waiting && reg_req_in && (reg_src_in == SRC_ID) &&
                 (reg_addr_in == addr_q) && (reg_rd_wr_L_in == rd_wr_L_q);

  assign done_ack     = match && reg_ack_in;
  assign done_noack   = match && !reg_ack_in;
  assign done_timeout = waiting && !match && (tmo_cnt == CNT_LAST);
  assign rdata        = reg_data_in;

endmodule

// File: rtl/ap_table_loader.sv
// Register-ring head that writes/reads AP table entries via staged registers.
// Define AP_LOADER_VERIFY_EN to append a read-back compare after each write.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | drive one ring request for the current step
// WAIT  | wait for matching return, no-ack or timeout
// RESP  | one-cycle response strobe
module ap_table_loader
  import ap_table_loader_pkg::*;
#(
  parameter int                           AP_WIDTH          = 32,
  parameter int                           ACTION_WIDTH      = 64,
  parameter int                           IDX_WIDTH         = 8,
  parameter logic [12:0]                  TAG               = 13'h1,
  parameter int                           REG_ADDR_WIDTH    = 10,
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = 2'd0,
  parameter int                           TIMEOUT_CYCLES    = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [IDX_WIDTH-1:0]         cmd_index,
  input  logic [ACTION_WIDTH-1:0]      cmd_action,
  input  logic [AP_WIDTH-1:0]          cmd_ap,
  output logic                         rsp_valid,
  output logic [ACTION_WIDTH-1:0]      rsp_action,
  output logic [AP_WIDTH-1:0]          rsp_ap,
  output logic [1:0]                   rsp_err,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [22:0]                  reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [22:0]                  reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in
);

  state_t                    state, state_nxt;
  logic [2:0]                step, last_step;
  logic                      is_wr;
  logic [IDX_WIDTH-1:0]      idx_q;
  logic [ACTION_WIDTH-1:0]   action_q;
  logic [AP_WIDTH-1:0]       ap_q;
  err_t                      err_q;
  logic                      accept, issue, waiting;
  logic                      step_rd_wr_L;
  logic [REG_ADDR_WIDTH-1:0] step_off;
  logic [RING_DATA_W-1:0]    step_data, rdata;
  logic                      done_ack, done_noack, done_timeout, verify_bad;

  // Steps 0-3 are the write phase, 4-7 the read phase; reads start at 4.
  always_comb begin
    step_rd_wr_L = 1'b0;
    step_off     = REG_ADDR_WIDTH'(AP_ACT_LO_OFF);
    step_data    = '0;
    case (step)
      3'd0: step_data = action_q[31:0];
      3'd1: begin step_off = REG_ADDR_WIDTH'(AP_ACT_HI_OFF);     step_data = action_q[63:32];          end
      3'd2: begin step_off = REG_ADDR_WIDTH'(AP_AP_OFF);         step_data = RING_DATA_W'(ap_q);       end
      3'd3: begin step_off = REG_ADDR_WIDTH'(AP_WRITE_ADDR_OFF); step_data = RING_DATA_W'(idx_q);      end
      3'd4: begin step_off = REG_ADDR_WIDTH'(AP_READ_ADDR_OFF);  step_data = RING_DATA_W'(idx_q);      end
      3'd5: step_rd_wr_L = 1'b1;
      3'd6: begin step_rd_wr_L = 1'b1; step_off = REG_ADDR_WIDTH'(AP_ACT_HI_OFF); end
      default: begin step_rd_wr_L = 1'b1; step_off = REG_ADDR_WIDTH'(AP_AP_OFF); end
    endcase
  end

`ifdef AP_LOADER_VERIFY_EN
  logic [RING_DATA_W-1:0] exp_word;

  assign last_step = 3'd7;

  always_comb begin
    case (step)
      3'd5:    exp_word = action_q[31:0];
      3'd6:    exp_word = action_q[63:32];
      default: exp_word = RING_DATA_W'(ap_q);
    endcase
  end

  assign verify_bad = is_wr && (rdata != exp_word);
`else
  assign last_step  = is_wr ? 3'd3 : 3'd7;
  assign verify_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done_ack)
          state_nxt = (step == last_step) ? RESP : ISSUE;
        else if (done_noack || done_timeout)
          state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
    issue     = (state == ISSUE);
    waiting   = (state == WAIT);
  end

  assign accept  = cmd_valid && cmd_ready;
  assign rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step       <= '0;
      is_wr      <= 1'b0;
      idx_q      <= '0;
      action_q   <= '0;
      ap_q       <= '0;
      err_q      <= ERR_OK;
      rsp_action <= '0;
      rsp_ap     <= '0;
    end else if (accept) begin
      step       <= cmd_wr ? 3'd0 : 3'd4;
      is_wr      <= cmd_wr;
      idx_q      <= cmd_index;
      action_q   <= cmd_action;
      ap_q       <= cmd_ap;
      err_q      <= ERR_OK;
      rsp_action <= '0;
      rsp_ap     <= '0;
    end else if (waiting) begin
      if (done_ack) begin
        step <= step + 3'd1;
        case (step)
          3'd5:    rsp_action[31:0]  <= rdata;
          3'd6:    rsp_action[63:32] <= rdata;
          3'd7:    rsp_ap            <= AP_WIDTH'(rdata);
          default: ;
        endcase
        if (step >= 3'd5 && verify_bad)
          err_q <= ERR_MISMATCH;
      end else if (done_noack || done_timeout) begin
        err_q      <= done_noack ? ERR_NOACK : ERR_TIMEOUT;
        rsp_action <= '0;
        rsp_ap     <= '0;
      end
    end
  end

  reg_ring_xact #(
    .UDP_REG_SRC_WIDTH (UDP_REG_SRC_WIDTH),
    .SRC_ID            (SRC_ID),
    .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
  ) u_xact (
    .clk             (clk),
    .reset           (reset),
    .issue           (issue),
    .waiting         (waiting),
    .rd_wr_L         (step_rd_wr_L),
    .addr            ({TAG, step_off}),
    .data            (step_data),
    .done_ack        (done_ack),
    .done_noack      (done_noack),
    .done_timeout    (done_timeout),
    .rdata           (rdata),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out),
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in)
  );

endmodule
